// File: rtl/mem_responder.sv
// Data-memory responder: one request in flight, fixed access latency,
// single-cycle Valid pulse carrying read data or an error flag.
module mem_responder #(
  parameter int N       = 32,
  parameter int DEPTH_W = 10,
  parameter int LATENCY = 3
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         MemEn,
  input  logic         MemWrEn,
  input  logic [N-1:0] MemAddr,
  input  logic [N-1:0] MemDataIn,
  output logic [N-1:0] MemOut,
  output logic         Valid,
  output logic         Err,
  output logic         Busy
);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  localparam int LOADV = (LATENCY >= 2) ? LATENCY - 2 : 0;

  state_t         state, nextState;
  logic [3:0]     cnt, nextCnt;
  logic           reqWr;
  logic [N-1:0]   reqAddr, reqData;

  logic           accept;
  logic           commit;
  logic           cWr;
  logic [N-1:0]   cAddr, cData;
  logic [DEPTH_W-1:0] wordIdx;
  logic           accErr;

  logic [N-1:0]   mem [2**DEPTH_W];

  assign accept = MemEn && (state != WAIT);
  assign Busy   = (state == WAIT);

  // The access that completes this edge comes straight from the ports when
  // LATENCY=1 (accept and commit coincide), otherwise from the latched request.
  always_comb begin
    nextState = state;
    nextCnt   = cnt;
    commit    = 1'b0;
    cWr       = reqWr;
    cAddr     = reqAddr;
    cData     = reqData;
    case (state)
      IDLE, RESP: begin
        if (MemEn) begin
          if (LATENCY == 1) begin
            nextState = RESP;
            commit    = 1'b1;
            cWr       = MemWrEn;
            cAddr     = MemAddr;
            cData     = MemDataIn;
          end else begin
            nextState = WAIT;
            nextCnt   = 4'(LOADV);
          end
        end else begin
          nextState = IDLE;
        end
      end
      WAIT: begin
        if (cnt == '0) begin
          nextState = RESP;
          commit    = 1'b1;
        end else begin
          nextCnt = cnt - 4'd1;
        end
      end
      default: nextState = IDLE;
    endcase
  end

  assign wordIdx = cAddr[DEPTH_W+1:2];
  assign accErr  = (cAddr[1:0] != 2'b00) || ((cAddr >> (DEPTH_W + 2)) != '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      cnt     <= '0;
      reqWr   <= 1'b0;
      reqAddr <= '0;
      reqData <= '0;
      MemOut  <= '0;
      Valid   <= 1'b0;
      Err     <= 1'b0;
    end else begin
      state <= nextState;
      cnt   <= nextCnt;
      if (accept) begin
        reqWr   <= MemWrEn;
        reqAddr <= MemAddr;
        reqData <= MemDataIn;
      end
      Valid <= commit;
      Err   <= commit && accErr;
      if (commit && accErr) begin
        MemOut <= '0;
      end else if (commit && !cWr) begin
        MemOut <= mem[wordIdx];
      end
    end
  end

  // Storage is not reset; a reset edge suppresses any pending commit.
  always_ff @(posedge clk) begin
    if (!rst && commit && cWr && !accErr) begin
      mem[wordIdx] <= cData;
    end
  end

endmodule

// File: tb/tb_mem_responder.sv
// Bench for mem_responder: LATENCY=3 and LATENCY=1 builds driven in parallel,
// checked every cycle against a request/countdown model plus literal checks.
module tb_mem_responder;

  logic        clk;
  logic        rst;
  logic        en, wr;
  logic [31:0] addr, data;
  logic [31:0] q3, q1;
  logic        v3, e3, b3, v1, e1, b1;

  int total = 0;
  int bad   = 0;
  bit chkOn = 0;

  mem_responder #(.N(32), .DEPTH_W(10), .LATENCY(3)) dut3 (
    .clk(clk), .rst(rst), .MemEn(en), .MemWrEn(wr), .MemAddr(addr),
    .MemDataIn(data), .MemOut(q3), .Valid(v3), .Err(e3), .Busy(b3)
  );

  mem_responder #(.N(32), .DEPTH_W(4), .LATENCY(1)) dut1 (
    .clk(clk), .rst(rst), .MemEn(en), .MemWrEn(wr), .MemAddr(addr),
    .MemDataIn(data), .MemOut(q1), .Valid(v1), .Err(e1), .Busy(b1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Model: rem = edges left before completion; 0 means ready to accept.
  typedef struct { bit wr; logic [31:0] addr; logic [31:0] data; } req_t;
  int          rem  [2];
  req_t        pend [2];
  bit          vE   [2];
  bit          eE   [2];
  bit          oK   [2];
  logic [31:0] oE   [2];
  logic [31:0] mm   [int];

  initial begin
    for (int m = 0; m < 2; m++) begin
      rem[m] = 0; vE[m] = 0; eE[m] = 0; oK[m] = 1; oE[m] = '0;
    end
  end

  task automatic complete(input int m, input int dw);
    req_t p;
    bit   isErr;
    int   key;
    p     = pend[m];
    isErr = (p.addr[1:0] != 2'b00) || ((p.addr >> (dw + 2)) != 0);
    key   = (m << 20) | int'(p.addr >> 2);
    vE[m] = 1;
    if (isErr) begin
      eE[m] = 1; oE[m] = '0; oK[m] = 1;
    end else if (p.wr) begin
      mm[key] = p.data;
    end else if (mm.exists(key)) begin
      oE[m] = mm[key]; oK[m] = 1;
    end else begin
      oK[m] = 0;
    end
  endtask

  task automatic modelEdge(input int m, input int lat, input int dw);
    if (rst) begin
      rem[m] = 0; vE[m] = 0; eE[m] = 0; oE[m] = '0; oK[m] = 1;
      return;
    end
    vE[m] = 0; eE[m] = 0;
    if (rem[m] > 0) begin
      rem[m] = rem[m] - 1;
      if (rem[m] == 0) complete(m, dw);
    end else if (en) begin
      pend[m] = '{wr, addr, data};
      rem[m]  = lat - 1;
      if (rem[m] == 0) complete(m, dw);
    end
  endtask

  always @(posedge clk) begin
    modelEdge(0, 3, 10);
    modelEdge(1, 1, 4);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (chkOn) begin
      chk("valid3", 32'(v3), 32'(vE[0]));
      chk("err3",   32'(e3), 32'(eE[0]));
      chk("busy3",  32'(b3), 32'(rem[0] > 0));
      if (oK[0]) chk("out3", q3, oE[0]);
      chk("valid1", 32'(v1), 32'(vE[1]));
      chk("err1",   32'(e1), 32'(eE[1]));
      chk("busy1",  32'(b1), 32'(rem[1] > 0));
      if (oK[1]) chk("out1", q1, oE[1]);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input bit e, input bit w, input logic [31:0] a, input logic [31:0] d);
    en = e; wr = w; addr = a; data = d;
  endtask

  // Present a request, then idle until the LATENCY=3 response cycle.
  task automatic op(input bit w, input logic [31:0] a, input logic [31:0] d);
    drive(1'b1, w, a, d);
    tick();
    en = 1'b0;
    tick();
    tick();
  endtask

  initial begin
    rst = 1'b1;
    drive(1'b0, 1'b0, '0, '0);
    tick();
    tick();
    rst   = 1'b0;
    chkOn = 1;
    @(negedge clk);
    chk("rst_out", q3, 32'h0);
    chk("rst_vld", 32'(v3), 32'h0);
    chk("rst_err", 32'(e3), 32'h0);
    chk("rst_bsy", 32'(b3), 32'h0);
    repeat (10) tick();

    op(1'b1, 32'h0,  32'h0000A0A0);
    op(1'b1, 32'h4,  32'h0000B4B4);
    op(1'b1, 32'h24, 32'h24242424);
    op(1'b1, 32'h30, 32'hAAAA5555);

    // Write then read issued in the RESP cycle.
    drive(1'b1, 1'b1, 32'h10, 32'hDEADBEEF);
    tick();
    en = 1'b0;
    @(negedge clk); chk("wr_busy_c1", 32'(b3), 32'h1);
    tick();
    @(negedge clk); chk("wr_busy_c2", 32'(b3), 32'h1);
    tick();
    @(negedge clk); chk("wr_valid", 32'(v3), 32'h1); chk("wr_err", 32'(e3), 32'h0);
    drive(1'b1, 1'b0, 32'h10, '0);
    tick();
    en = 1'b0;
    tick();
    tick();
    @(negedge clk); chk("rd_valid", 32'(v3), 32'h1); chk("rd_data", q3, 32'hDEADBEEF);

    op(1'b0, 32'h12, '0);
    @(negedge clk); chk("mis_err", 32'(e3), 32'h1); chk("mis_out", q3, 32'h0);
    op(1'b1, 32'h1000, 32'h12345678);
    @(negedge clk); chk("oor_err", 32'(e3), 32'h1);
    op(1'b0, 32'h0, '0);
    @(negedge clk); chk("oor_nowr", q3, 32'h0000A0A0);

    // Second request lands while busy and must be dropped.
    drive(1'b1, 1'b1, 32'h20, 32'h11111111);
    tick();
    drive(1'b1, 1'b1, 32'h24, 32'h22222222);
    tick();
    en = 1'b0;
    tick();
    @(negedge clk); chk("drop_v1", 32'(v3), 32'h1);
    tick();
    @(negedge clk); chk("drop_v2", 32'(v3), 32'h0);
    op(1'b0, 32'h24, '0);
    @(negedge clk); chk("drop_data", q3, 32'h24242424);

    // Reset during WAIT aborts the write.
    drive(1'b1, 1'b1, 32'h30, 32'hCAFEF00D);
    tick();
    rst = 1'b1;
    en  = 1'b0;
    tick();
    rst = 1'b0;
    @(negedge clk); chk("abort_bsy", 32'(b3), 32'h0); chk("abort_vld", 32'(v3), 32'h0);
    tick();
    @(negedge clk); chk("abort_vld2", 32'(v3), 32'h0);
    op(1'b0, 32'h30, '0);
    @(negedge clk); chk("abort_data", q3, 32'hAAAA5555);

    // Back-to-back reads on the LATENCY=1 build.
    drive(1'b1, 1'b0, 32'h0, '0);
    tick();
    @(negedge clk); chk("l1_v0", 32'(v1), 32'h1); chk("l1_d0", q1, 32'h0000A0A0);
    drive(1'b1, 1'b0, 32'h4, '0);
    tick();
    @(negedge clk); chk("l1_v1", 32'(v1), 32'h1); chk("l1_d1", q1, 32'h0000B4B4);
    chk("l1_bsy", 32'(b1), 32'h0);
    en = 1'b0;
    repeat (4) tick();

    for (int i = 0; i < 800; i++) begin
      int r;
      rst = ($urandom_range(0, 99) == 0);
      en  = $urandom_range(0, 1) != 0;
      wr  = $urandom_range(0, 1) != 0;
      r   = int'($urandom_range(0, 9));
      if (r < 7)       addr = 32'($urandom_range(0, 15)) << 2;
      else if (r == 7) addr = ($urandom_range(0, 1) != 0) ? 32'hFFC : 32'h40;
      else if (r == 8) addr = (32'($urandom_range(0, 15)) << 2) | 32'($urandom_range(1, 3));
      else             addr = 32'h1000 | (32'($urandom_range(0, 255)) << 2);
      data = $urandom;
      tick();
    end
    rst = 1'b0;
    en  = 1'b0;
    repeat (5) tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
